// File: rtl/xs3_serial_adder.sv
// Digit-serial excess-3 adder: one XS-3 digit per clock, LSD first, done pulse on completion.
// Optional subtract mode is enabled by defining XS3_SUB_EN.
module xs3_serial_adder #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    // A digit outside 0011..1100 is not a legal XS-3 code
    function automatic logic digit_bad(input logic [3:0] d);
        return (d < 4'd3) || (d > 4'd12);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                c_q, c_d, cout_q, cout_d, err_q, err_d;
    logic                busy_q, done_q;
    logic                sub_q, sub_d;
    logic                init_c_s;
    logic [3:0]          b_eff_s, digit_s;
    logic [4:0]          t_s;

`ifdef XS3_SUB_EN
    // Inverting an XS-3 digit gives its 9's complement; forced carry makes it ten's complement
    assign b_eff_s  = sub_q ? ~b_q[3:0] : b_q[3:0];
    assign init_c_s = sub ? 1'b1 : Cin;
    assign sub_d    = (state_q == S_IDLE && start) ? sub : sub_q;
`else
    logic sub_unused_s;
    assign sub_unused_s = sub;
    assign b_eff_s  = b_q[3:0];
    assign init_c_s = Cin;
    assign sub_d    = 1'b0;
`endif

    assign t_s     = {1'b0, a_q[3:0]} + {1'b0, b_eff_s} + {4'd0, c_q};
    assign digit_s = t_s[4] ? (t_s[3:0] + 4'd3) : (t_s[3:0] + 4'd13);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = init_c_s;
                    idx_d   = {CNT_W{1'b0}};
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == CNT_W'(i)) begin
                        sum_d[4*i +: 4] = digit_s;
                    end else begin
                        sum_d[4*i +: 4] = sum_q[4*i +: 4];
                    end
                end
                err_d = err_q | digit_bad(a_q[3:0]) | digit_bad(b_q[3:0]);
                a_d   = a_q >> 3'd4;
                b_d   = b_q >> 3'd4;
                c_d   = t_s[4];
                if (idx_q == LAST_IDX) begin
                    cout_d  = t_s[4];
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= {CNT_W{1'b0}};
            a_q     <= {(4*DIGITS){1'b0}};
            b_q     <= {(4*DIGITS){1'b0}};
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            sum_q   <= {(4*DIGITS){1'b0}};
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Self-checking bench for xs3_serial_adder (DIGITS=4): directed vector table,
// handshake/reset sequences and randomized operations against a decimal model.
module tb_xs3_serial_adder;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst, start, Cin, sub;
    logic [15:0] A, B;
    logic        busy, done, Cout, err;
    logic [15:0] Sum;

    int n_checks = 0;
    int n_fail   = 0;

    xs3_serial_adder #(.DIGITS(D), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sb;
        logic [15:0] sum;
        logic        cout, err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int xs3_to_dec(input logic [15:0] x);
        int v = 0;
        for (int i = D-1; i >= 0; i--) v = v*10 + (int'(x[4*i +: 4]) - 3);
        return v;
    endfunction

    function automatic logic [15:0] dec_to_xs3(input int v);
        logic [15:0] r;
        int w = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((w % 10) + 3);
            w = w / 10;
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [15:0] x);
        logic bad = 1'b0;
        for (int i = 0; i < D; i++)
            if (x[4*i +: 4] < 4'd3 || x[4*i +: 4] > 4'd12) bad = 1'b1;
        return bad;
    endfunction

    // Issue one operation, wait (bounded) for done, check latency/busy length
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sb, output logic [15:0] rs, output logic rc,
                          output logic re);
        int lat = 0;
        int bcnt = 0;
        @(negedge clk);
        A = a; B = b; Cin = cin; sub = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) bcnt++;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        rs = Sum; rc = Cout; re = err;
        chk("latency", lat, D);
        @(posedge clk); #1;
        chk("busy_cycles", bcnt, D + 1);
        chk("idle_after_done", {busy, done}, 2'b00);
    endtask

    logic [15:0] rs;
    logic        rc, re;

    initial begin
        rst = 1'b1; start = 1'b0; A = 16'h0; B = 16'h0; Cin = 1'b0; sub = 1'b0;

        vecs.push_back('{16'h4567, 16'h89AB, 1'b0, 1'b0, 16'h9C45, 1'b0, 1'b0});
        vecs.push_back('{16'hCCCC, 16'h3334, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b0});
        vecs.push_back('{16'h3333, 16'h3333, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0});
        vecs.push_back('{16'h0567, 16'h89AB, 1'b0, 1'b0, 16'h5C45, 1'b0, 1'b1});
        vecs.push_back('{16'h3333, 16'h3333, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0});
        vecs.push_back('{16'hCCCC, 16'hCCCC, 1'b1, 1'b0, 16'hCCCC, 1'b1, 1'b0});
`ifdef XS3_SUB_EN
        vecs.push_back('{16'h89AB, 16'h4567, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0});
        vecs.push_back('{16'h4567, 16'h89AB, 1'b0, 1'b1, 16'h8889, 1'b0, 1'b0});
        vecs.push_back('{16'h4567, 16'h4567, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0});
`else
        vecs.push_back('{16'h4567, 16'h89AB, 1'b0, 1'b1, 16'h9C45, 1'b0, 1'b0});
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_sum", Sum, 16'h0);
        chk("reset_cout", Cout, 1'b0);
        chk("reset_err", err, 1'b0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, rs, rc, re);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), rc, vecs[i].cout);
            chk($sformatf("vec%0d_err", i), re, vecs[i].err);
        end

        // Handshake: start pulses in RUN and DONE are ignored
        begin
            int dcnt = 0;
            @(negedge clk);
            A = 16'h4567; B = 16'h89AB; Cin = 1'b0; sub = 1'b0; start = 1'b1;
            @(posedge clk);
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (done) dcnt++;
                if (n == D) chk("hs_done_cycle", done, 1'b1);
                A = 16'h3333; B = 16'h3333; Cin = 1'b1;
                start = (n == 1 || n == D) ? 1'b1 : 1'b0;
            end
            start = 1'b0;
            chk("hs_done_count", dcnt, 1);
            chk("hs_sum_hold", Sum, 16'h9C45);
            chk("hs_idle", busy, 1'b0);
            // New start accepted; Sum holds previous result just after the start edge
            @(negedge clk); start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            chk("hs_sum_held_at_start", Sum, 16'h9C45);
            chk("hs_busy_at_start", busy, 1'b1);
            repeat (D) @(posedge clk);
            #1;
            chk("hs_second_done", done, 1'b1);
            chk("hs_second_sum", Sum, 16'h3334);
        end

        // Reset two cycles into RUN aborts without a done pulse
        begin
            int dcnt = 0;
            @(negedge clk);
            A = 16'h4567; B = 16'h89AB; Cin = 1'b0; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            chk("abort_busy", busy, 1'b0);
            chk("abort_sum", Sum, 16'h0);
            @(negedge clk); rst = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (done) dcnt++;
            end
            chk("abort_no_done", dcnt, 0);
        end

        // Randomized operations against a decimal model
        for (int k = 0; k < 40; k++) begin
            int da, db, ci, exp_v, sb;
            logic [15:0] xa, xb;
            logic inj;
            da = int'($urandom_range(0, 9999));
            db = int'($urandom_range(0, 9999));
            ci = int'($urandom_range(0, 1));
`ifdef XS3_SUB_EN
            sb = int'($urandom_range(0, 1));
`else
            sb = 0;
`endif
            xa = dec_to_xs3(da);
            xb = dec_to_xs3(db);
            inj = ($urandom_range(0, 7) == 0);
            if (inj) xb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(0, 2));
            run_op(xa, xb, ci[0], sb[0], rs, rc, re);
            chk($sformatf("rnd%0d_err", k), re, any_bad(xa) | any_bad(xb));
            if (!inj) begin
                if (sb != 0) exp_v = da + (9999 - db) + 1;
                else         exp_v = da + db + ci;
                chk($sformatf("rnd%0d_sum", k), rs, dec_to_xs3(exp_v % 10000));
                chk($sformatf("rnd%0d_cout", k), rc, (exp_v >= 10000) ? 1'b1 : 1'b0);
                chk($sformatf("rnd%0d_dec", k), xs3_to_dec(rs), exp_v % 10000);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
